// File: rtl/result_window_accumulator.sv
// -----------------------------------------------------------------------------
// result_window_accumulator
//
// Purpose:
//   Sums fixed-length windows of consecutive valid result words coming from a
//   compute unit. Each window sum is held in a one-deep registered output slot
//   with a valid/ready handshake. The input is never stalled. A window that
//   closes while the slot is still occupied is dropped and counted.
//
// Ports:
//   clk            clock, rising edge
//   reset          synchronous, active-high reset
//   result_in      result word (unsigned, resultWidth bits)
//   result_valid   result_in is meaningful this cycle
//   flush          close the current window early (partial window)
//   sum_out        window sum (sumWidth bits)
//   sum_count      number of results contained in sum_out
//   sum_partial    sum_out came from a flush rather than a full window
//   sum_valid      output slot occupied
//   sum_ready      downstream accepts sum_out when high with sum_valid
//   overrun        sticky: at least one window was dropped
//   overrun_count  number of dropped windows, saturating at all-ones
//
// Optional feature (macro RESULT_ACC_SATURATE_EN):
//   When defined, an addition that overflows sumWidth clamps the accumulator
//   to all-ones for the rest of the window. When undefined, the accumulator
//   wraps modulo 2^sumWidth.
// -----------------------------------------------------------------------------
module result_window_accumulator #(
  parameter int resultWidth  = 32,
  parameter int sumWidth     = 40,
  parameter int windowLength = 16,
  parameter int countWidth   = 8,
  parameter int overrunWidth = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [resultWidth-1:0]  result_in,
  input  logic                    result_valid,
  input  logic                    flush,
  output logic [sumWidth-1:0]     sum_out,
  output logic [countWidth-1:0]   sum_count,
  output logic                    sum_partial,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic                    overrun,
  output logic [overrunWidth-1:0] overrun_count
);

  localparam logic [countWidth-1:0] LAST_IDX = countWidth'(windowLength - 1);
  localparam logic [countWidth-1:0] FULL_CNT = countWidth'(windowLength);

  logic [sumWidth-1:0]     acc_reg, acc_next;
  logic [countWidth-1:0]   sample_cnt_reg, sample_cnt_next;
  logic [sumWidth-1:0]     sum_out_reg, sum_out_next;
  logic [countWidth-1:0]   sum_count_reg, sum_count_next;
  logic                    sum_partial_reg, sum_partial_next;
  logic                    sum_valid_reg, sum_valid_next;
  logic                    overrun_reg, overrun_next;
  logic [overrunWidth-1:0] overrun_count_reg, overrun_count_next;

  logic [sumWidth-1:0]     add_sum;
  logic [sumWidth-1:0]     window_sum;
  logic [countWidth-1:0]   window_cnt;
  logic                    full_close, flush_close, any_close, slot_free;

`ifdef RESULT_ACC_SATURATE_EN
  // One extra bit catches the carry; once acc is all-ones any nonzero
  // addition carries again, so the window stays clamped.
  logic [sumWidth:0] add_wide;
  assign add_wide = {1'b0, acc_reg} + (sumWidth + 1)'(result_in);
  assign add_sum  = add_wide[sumWidth] ? {sumWidth{1'b1}} : add_wide[sumWidth-1:0];
`else
  assign add_sum = acc_reg + sumWidth'(result_in);
`endif

  // window_sum/window_cnt describe the window as it would close this cycle,
  // including the sample arriving now.
  assign window_sum  = result_valid ? add_sum : acc_reg;
  assign window_cnt  = sample_cnt_reg + countWidth'(result_valid);
  assign full_close  = result_valid && (sample_cnt_reg == LAST_IDX);
  // A flush coinciding with a full close is absorbed by it; an empty flush
  // is a no-op.
  assign flush_close = flush && !full_close && (window_cnt != '0);
  assign any_close   = full_close || flush_close;
  assign slot_free   = !sum_valid_reg || sum_ready;

  always_comb begin
    acc_next           = window_sum;
    sample_cnt_next    = window_cnt;
    sum_out_next       = sum_out_reg;
    sum_count_next     = sum_count_reg;
    sum_partial_next   = sum_partial_reg;
    sum_valid_next     = sum_valid_reg && !sum_ready;
    overrun_next       = overrun_reg;
    overrun_count_next = overrun_count_reg;

    if (any_close) begin
      acc_next        = '0;
      sample_cnt_next = '0;
      if (slot_free) begin
        sum_out_next     = window_sum;
        sum_count_next   = full_close ? FULL_CNT : window_cnt;
        sum_partial_next = !full_close;
        sum_valid_next   = 1'b1;
      end else begin
        overrun_next = 1'b1;
        if (overrun_count_reg != {overrunWidth{1'b1}}) begin
          overrun_count_next = overrun_count_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg           <= '0;
      sample_cnt_reg    <= '0;
      sum_out_reg       <= '0;
      sum_count_reg     <= '0;
      sum_partial_reg   <= 1'b0;
      sum_valid_reg     <= 1'b0;
      overrun_reg       <= 1'b0;
      overrun_count_reg <= '0;
    end else begin
      acc_reg           <= acc_next;
      sample_cnt_reg    <= sample_cnt_next;
      sum_out_reg       <= sum_out_next;
      sum_count_reg     <= sum_count_next;
      sum_partial_reg   <= sum_partial_next;
      sum_valid_reg     <= sum_valid_next;
      overrun_reg       <= overrun_next;
      overrun_count_reg <= overrun_count_next;
    end
  end

  assign sum_out       = sum_out_reg;
  assign sum_count     = sum_count_reg;
  assign sum_partial   = sum_partial_reg;
  assign sum_valid     = sum_valid_reg;
  assign overrun       = overrun_reg;
  assign overrun_count = overrun_count_reg;

endmodule

// File: tb/tb_result_window_accumulator.sv
module tb_result_window_accumulator;

  logic        clk;
  logic        reset;
  logic [31:0] result_in;
  logic        result_valid;
  logic        flush;
  logic [39:0] sum_out;
  logic [7:0]  sum_count;
  logic        sum_partial;
  logic        sum_valid;
  logic        sum_ready;
  logic        overrun;
  logic [7:0]  overrun_count;

  // Narrow-accumulator instance for the overflow / saturation case.
  logic [31:0] r33_in;
  logic        r33_valid;
  logic [32:0] s33_out;
  logic [7:0]  s33_count;
  logic        s33_partial;
  logic        s33_valid;
  logic        s33_overrun;
  logic [7:0]  s33_overrun_count;

  typedef struct {
    logic [63:0] s;
    logic [63:0] c;
    logic [63:0] p;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  result_window_accumulator dut (
    .clk(clk), .reset(reset), .result_in(result_in), .result_valid(result_valid),
    .flush(flush), .sum_out(sum_out), .sum_count(sum_count), .sum_partial(sum_partial),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .overrun(overrun),
    .overrun_count(overrun_count)
  );

  result_window_accumulator #(.sumWidth(33)) dut33 (
    .clk(clk), .reset(reset), .result_in(r33_in), .result_valid(r33_valid),
    .flush(1'b0), .sum_out(s33_out), .sum_count(s33_count), .sum_partial(s33_partial),
    .sum_valid(s33_valid), .sum_ready(1'b1), .overrun(s33_overrun),
    .overrun_count(s33_overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [63:0] s, input logic [63:0] c, input logic [63:0] p);
    exp_t e;
    e.s = s; e.c = c; e.p = p;
    exp_q.push_back(e);
  endtask

  // Scoreboard pop: every accepted output must match the oldest expectation.
  task automatic monitor();
    exp_t e;
    if (sum_valid === 1'b1 && sum_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(sum_out), 64'hDEAD_0000_0000);
      end else begin
        e = exp_q.pop_front();
        chk("sum_out", 64'(sum_out), e.s);
        chk("sum_count", 64'(sum_count), e.c);
        chk("sum_partial", 64'(sum_partial), e.p);
        $display("txn: sum_out=%0h count=%0d partial=%0d", sum_out, sum_count, sum_partial);
      end
    end
  endtask

  // Drive one cycle of inputs (called at a negedge), check, advance one clock.
  task automatic cyc(input logic v, input logic [31:0] d, input logic f, input logic rdy);
    result_valid = v;
    result_in    = d;
    flush        = f;
    sum_ready    = rdy;
    #1;
    monitor();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; result_in = '0; result_valid = 1'b0; flush = 1'b0; sum_ready = 1'b0;
    r33_in = '0; r33_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sum_valid", 64'(sum_valid), 64'd0);
    chk("rst_sum_out", 64'(sum_out), 64'd0);
    chk("rst_sum_count", 64'(sum_count), 64'd0);
    chk("rst_sum_partial", 64'(sum_partial), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_overrun_count", 64'(overrun_count), 64'd0);
    reset = 1'b0;

    // 16 consecutive results of 5.
    for (int i = 0; i < 16; i++) begin
      if (i == 15) push(64'd80, 64'd16, 64'd0);
      cyc(1'b1, 32'd5, 1'b0, 1'b1);
    end
    chk("t1_latency_valid", 64'(sum_valid), 64'd1);
    repeat (2) cyc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("t1_overrun", 64'(overrun), 64'd0);
    chk("t1_drained", 64'(exp_q.size()), 64'd0);

    // 1..16 with valid toggling every cycle.
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) push(64'd136, 64'd16, 64'd0);
      cyc(1'b1, 32'(i), 1'b0, 1'b1);
      cyc(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    end

    // Five results of 100 then a flush with no valid result.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'd100, 1'b0, 1'b1);
    push(64'd500, 64'd5, 64'd1);
    cyc(1'b0, 32'd0, 1'b1, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    // Flush on an empty window emits nothing.
    cyc(1'b0, 32'd0, 1'b1, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("empty_flush_no_valid", 64'(sum_valid), 64'd0);
    chk("empty_flush_drained", 64'(exp_q.size()), 64'd0);

    // Flush together with a valid result on an empty window.
    push(64'd7, 64'd1, 64'd1);
    cyc(1'b1, 32'd7, 1'b1, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);

    // Flush coincident with a full close, then the next window starts empty.
    for (int i = 0; i < 15; i++) cyc(1'b1, 32'd3, 1'b0, 1'b1);
    push(64'd48, 64'd16, 64'd0);
    cyc(1'b1, 32'd3, 1'b1, 1'b1);
    cyc(1'b1, 32'd1, 1'b0, 1'b1);
    push(64'd2, 64'd2, 64'd1);
    cyc(1'b1, 32'd1, 1'b1, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);

    // Two full windows of 1s with sum_ready held low.
    for (int i = 0; i < 16; i++) begin
      if (i == 15) push(64'd16, 64'd16, 64'd0);
      cyc(1'b1, 32'd1, 1'b0, 1'b0);
    end
    chk("hold_valid", 64'(sum_valid), 64'd1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 32'd1, 1'b0, 1'b0);
      chk("hold_stable_sum", 64'(sum_out), 64'd16);
    end
    chk("hold_count", 64'(sum_count), 64'd16);
    chk("hold_partial", 64'(sum_partial), 64'd0);
    chk("overrun_flag", 64'(overrun), 64'd1);
    chk("overrun_count", 64'(overrun_count), 64'd1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("accept_drops_valid", 64'(sum_valid), 64'd0);
    chk("accept_sum_held", 64'(sum_out), 64'd16);
    chk("overrun_still_set", 64'(overrun), 64'd1);

    // Reset in the middle of a window discards the partial sum.
    for (int i = 0; i < 7; i++) cyc(1'b1, 32'd9, 1'b0, 1'b1);
    reset = 1'b1;
    result_valid = 1'b1; result_in = 32'd9;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_overrun", 64'(overrun), 64'd0);
    chk("midrst_overrun_count", 64'(overrun_count), 64'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) push(64'd32, 64'd16, 64'd0);
      cyc(1'b1, 32'd2, 1'b0, 1'b1);
    end
    cyc(1'b0, 32'd0, 1'b0, 1'b1);

    // All-ones results: no overflow at 40 bits; overflow at 33 bits.
    r33_valid = 1'b1; r33_in = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) push(64'hF_FFFF_FFF0, 64'd16, 64'd0);
      cyc(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    end
    r33_valid = 1'b0;
    chk("w33_valid", 64'(s33_valid), 64'd1);
`ifdef RESULT_ACC_SATURATE_EN
    chk("w33_sum", 64'(s33_out), 64'h1_FFFF_FFFF);
`else
    chk("w33_sum", 64'(s33_out), 64'h1_FFFF_FFF0);
`endif
    chk("w33_count", 64'(s33_count), 64'd16);
    $display("txn: w33 sum_out=%0h count=%0d", s33_out, s33_count);

    repeat (3) cyc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
